capture_seq_ctrl: RTL and testbench
===================================

Name: capture_seq_ctrl

Overview:
- Sequences one acquisition session on the PCIe side of the channel datapath.
- Arms the channel record-enable, clears the size statistics, and issues source-FIFO reads toward the DDR3 FIFO until a programmed byte length is reached or software stops it.
- Drains residual data, then reports done.
- Sits between the control-register decode and the channel FIFO read port. It replaces the static rec_en and rd_en equations with a managed session.

Parameters:
- BYTES_PER_WORD, 4, bytes credited per source read (32-bit word).
- DRAIN_IDLE, 16, consecutive src_empty cycles in DRAIN before DONE; covers async-FIFO flag latency.
- TIMEOUT_CYCLES, 1000000, CAPTURE watchdog limit (optional feature only).

Ports:
- clk_pcie  in  1  sole clock, all logic on its rising edge.
- data_path_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle session start pulse.
- stop  in  1  single-cycle session stop pulse.
- capture_len  in  64  target bytes; 0 = unlimited (runs until stop); sampled in CLEAR.
- src_empty  in  1  source FIFO empty (read side).
- src_full  in  1  source FIFO full (already synchronised into clk_pcie).
- ddr3_fifo_full  in  1  downstream backpressure.
- rec_en  out  1  channel write enable toward source FIFO.
- src_rd_en  out  1  source FIFO read strobe.
- size_clear  out  1  one-cycle pulse clearing total-size statistics.
- byte_count  out  64  bytes read this session.
- busy  out  1  state is CLEAR, CAPTURE or DRAIN.
- done  out  1  state is DONE.
- overflow  out  1  sticky: src_full seen while rec_en=1.
- state_o  out  3  encoded state for status register.

Behaviour:
- Reset (async): state IDLE; every output 0; latched length 0; drain counter 0.
- States: IDLE=0, CLEAR=1, CAPTURE=2, DRAIN=3, DONE=4.
- IDLE:
  - start -> CLEAR.
  - stop ignored.
  - start and stop in the same cycle -> CLEAR, stop discarded.
- CLEAR: exactly 1 cycle.
  - size_clear=1.
  - byte_count<=0, overflow<=0.
  - Latch capture_len.
  - Next state CAPTURE; if stop arrives in this cycle, next state DRAIN.
- CAPTURE: rec_en=1.
- Read rule (CAPTURE and DRAIN): src_rd_en = !src_empty & !ddr3_fifo_full & (len==0 | byte_count<len).
  - Combinational, zero latency.
  - Each asserted cycle adds BYTES_PER_WORD to byte_count on the next edge.
  - When len is not a multiple of BYTES_PER_WORD, the final read may overshoot len by up to BYTES_PER_WORD-1. This is allowed.
- CAPTURE -> DRAIN when either holds:
  - stop asserted;
  - len!=0 and the current read brings byte_count+BYTES_PER_WORD >= len.
- rec_en deasserts in the same cycle state becomes DRAIN (registered next-state decode). No extra write cycles are allowed.
- DRAIN: rec_en=0, reads continue per the read rule.
  - Drain counter increments while src_empty=1 and clears to 0 when src_empty=0.
  - Counter reaching DRAIN_IDLE-1 -> DONE.
  - If len is reached in DRAIN, reads stop; the counter still runs on src_empty only. Residual data stays in the FIFO for the next reset.
- DONE: done=1.
  - byte_count and overflow hold.
  - start -> CLEAR; stop ignored.
- overflow: set on any cycle with rec_en=1 and src_full=1; cleared only in CLEAR or by reset.
- byte_count wraps modulo 2^64 in unlimited mode; no saturation.
- ddr3_fifo_full held high indefinitely: session stalls, no timeout (unless feature enabled), state unchanged.
- Reset mid-session: immediate return to IDLE; all outputs 0 asynchronously.

Optional Feature:
- Macro: CAPTURE_TIMEOUT_EN.
- With it defined:
  - A watchdog counts CAPTURE cycles with src_rd_en=0 and resets on any read.
  - On reaching TIMEOUT_CYCLES it forces CAPTURE -> DRAIN.
  - It sets a sticky extra output timeout (1 bit, reset 0, cleared in CLEAR).
- Without it: no counter, no timeout port; CAPTURE exits only via stop or length.

Decomposition:
- Shared package data_path_pkg holds:
  - state encodings (IDLE..DONE, 3-bit);
  - BYTES_PER_WORD default;
  - status-register bit positions for busy/done/overflow/timeout.
- One natural sub-module: capture_drain_timer. It is the DRAIN_IDLE idle-run counter, reused as the watchdog when CAPTURE_TIMEOUT_EN is set.
- The FSM and read gating stay in the top block.

Test Plan:
1. Reset asserted mid-CAPTURE with byte_count=40 -> next sample: state_o=0, rec_en=0, src_rd_en=0, byte_count=0, overflow=0.
2. capture_len=16, src_empty=0, ddr3_fifo_full=0, start pulse:
   - size_clear high exactly 1 cycle;
   - 4 consecutive reads, byte_count=16;
   - rec_en falls on the cycle after the 4th read;
   - src_empty raised -> done 16 cycles later.
3. capture_len=10 -> exactly 3 reads, byte_count=12, then no further src_rd_en.
4. capture_len=0, 100 reads, then stop -> byte_count=400, DRAIN, rec_en=0; further reads continue until src_empty held 16 cycles -> DONE.
5. ddr3_fifo_full=1 for 50 cycles during CAPTURE -> src_rd_en=0 throughout, byte_count frozen; resumes the cycle after full drops. src_full pulse with rec_en=1 -> overflow=1, held through DONE, cleared on next start's CLEAR.
6. Start and stop in the same IDLE cycle -> CLEAR then CAPTURE (stop ignored). CAPTURE_TIMEOUT_EN with TIMEOUT_CYCLES=8 and src_empty=1 -> timeout=1, DRAIN after 8 idle cycles.

Source files
------------

// File: rtl/data_path_pkg.sv
// Shared definitions for the channel data-path control blocks: session state
// encoding, word size and status-register bit positions.
package data_path_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } cap_state_t;

  localparam int BYTES_PER_WORD_DEF = 4;

  localparam int STAT_BUSY_BIT     = 0;
  localparam int STAT_DONE_BIT     = 1;
  localparam int STAT_OVERFLOW_BIT = 2;
  localparam int STAT_TIMEOUT_BIT  = 3;

  function automatic logic state_is_busy(input cap_state_t s);
    return (s == ST_CLEAR) || (s == ST_CAPTURE) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/capture_drain_timer.sv
// Run-length counter: counts consecutive qualifying cycles and flags the cycle
// that completes LIMIT of them. Used for the drain idle run and the watchdog.
module capture_drain_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic hit
);

  localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  // hit fires on the LIMIT-th consecutive qualifying cycle, one edge before wrap
  assign hit = inc && (count == LAST);

endmodule

// File: rtl/capture_seq_ctrl.sv
// Acquisition session sequencer: arms record-enable, clears statistics, gates
// source-FIFO reads up to a byte length, drains, then reports done.
// Optional capture watchdog and sticky timeout output: CAPTURE_TIMEOUT_EN.
module capture_seq_ctrl
  import data_path_pkg::*;
#(
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int DRAIN_IDLE     = 16
`ifdef CAPTURE_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
  input  logic        clk_pcie,
  input  logic        data_path_rst,
  input  logic        start,
  input  logic        stop,
  input  logic [63:0] capture_len,
  input  logic        src_empty,
  input  logic        src_full,
  input  logic        ddr3_fifo_full,
  output logic        rec_en,
  output logic        src_rd_en,
  output logic        size_clear,
  output logic [63:0] byte_count,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic [2:0]  state_o
`ifdef CAPTURE_TIMEOUT_EN
  , output logic      timeout
`endif
);

  cap_state_t  state, next_state;
  logic [63:0] len_q;
  logic [64:0] bc_plus_word;
  logic        len_ok, len_hit, drain_hit, wd_hit;

  // Read gating is purely combinational so a read lands the same cycle data is offered
  assign len_ok       = (len_q == 64'd0) || (byte_count < len_q);
  assign src_rd_en    = ((state == ST_CAPTURE) || (state == ST_DRAIN)) &&
                        !src_empty && !ddr3_fifo_full && len_ok;
  assign bc_plus_word = {1'b0, byte_count} + 65'(BYTES_PER_WORD);
  assign len_hit      = src_rd_en && (len_q != 64'd0) && (bc_plus_word >= {1'b0, len_q});

  capture_drain_timer #(.LIMIT(DRAIN_IDLE)) u_drain_timer (
    .clk   (clk_pcie),
    .rst   (data_path_rst),
    .clear ((state != ST_DRAIN) || !src_empty),
    .inc   ((state == ST_DRAIN) && src_empty),
    .hit   (drain_hit)
  );

`ifdef CAPTURE_TIMEOUT_EN
  capture_drain_timer #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk   (clk_pcie),
    .rst   (data_path_rst),
    .clear ((state != ST_CAPTURE) || src_rd_en),
    .inc   ((state == ST_CAPTURE) && !src_rd_en),
    .hit   (wd_hit)
  );

  always_ff @(posedge clk_pcie or posedge data_path_rst) begin
    if (data_path_rst) begin
      timeout <= 1'b0;
    end else if (state == ST_CLEAR) begin
      timeout <= 1'b0;
    end else if (wd_hit) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:    if (start) next_state = ST_CLEAR;
      ST_CLEAR:   next_state = stop ? ST_DRAIN : ST_CAPTURE;
      ST_CAPTURE: if (stop || len_hit || wd_hit) next_state = ST_DRAIN;
      ST_DRAIN:   if (drain_hit) next_state = ST_DONE;
      ST_DONE:    if (start) next_state = ST_CLEAR;
      default:    next_state = ST_IDLE;
    endcase
  end

  // rec_en is decoded from next_state so it drops on the very edge DRAIN is entered
  always_ff @(posedge clk_pcie or posedge data_path_rst) begin
    if (data_path_rst) begin
      state      <= ST_IDLE;
      rec_en     <= 1'b0;
      len_q      <= 64'd0;
      byte_count <= 64'd0;
      overflow   <= 1'b0;
    end else begin
      state  <= next_state;
      rec_en <= (next_state == ST_CAPTURE);
      if (state == ST_CLEAR) begin
        len_q      <= capture_len;
        byte_count <= 64'd0;
        overflow   <= 1'b0;
      end else begin
        if (src_rd_en) begin
          byte_count <= byte_count + 64'(BYTES_PER_WORD);
        end
        if (rec_en && src_full) begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign size_clear = (state == ST_CLEAR);
  assign busy       = state_is_busy(state);
  assign done       = (state == ST_DONE);
  assign state_o    = state;

endmodule

// File: tb/tb_capture_seq_ctrl.sv
// Directed bench for capture_seq_ctrl; session results go through a scoreboard
// queue filled at session start and drained when done is reported.
module tb_capture_seq_ctrl;

  logic        clk_pcie = 1'b0;
  logic        data_path_rst;
  logic        start, stop;
  logic [63:0] capture_len;
  logic        src_empty, src_full, ddr3_fifo_full;
  logic        rec_en, src_rd_en, size_clear, busy, done, overflow;
  logic [63:0] byte_count;
  logic [2:0]  state_o;
`ifdef CAPTURE_TIMEOUT_EN
  logic        timeout;
  localparam int STALL = 5;
`else
  localparam int STALL = 50;
`endif

  typedef struct {
    string           tag;
    longint unsigned bytes;
    int              reads;
    int              base;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   rd_total = 0;
  int   viol;

  capture_seq_ctrl #(
    .BYTES_PER_WORD (4),
    .DRAIN_IDLE     (16)
`ifdef CAPTURE_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk_pcie       (clk_pcie),
    .data_path_rst  (data_path_rst),
    .start          (start),
    .stop           (stop),
    .capture_len    (capture_len),
    .src_empty      (src_empty),
    .src_full       (src_full),
    .ddr3_fifo_full (ddr3_fifo_full),
    .rec_en         (rec_en),
    .src_rd_en      (src_rd_en),
    .size_clear     (size_clear),
    .byte_count     (byte_count),
    .busy           (busy),
    .done           (done),
    .overflow       (overflow),
    .state_o        (state_o)
`ifdef CAPTURE_TIMEOUT_EN
    , .timeout      (timeout)
`endif
  );

  always #5 clk_pcie = ~clk_pcie;

  always @(negedge clk_pcie) begin
    if (src_rd_en === 1'b1) rd_total++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_time_limit observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit");
  end

  task automatic tick();
    @(posedge clk_pcie);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    start = s;
    stop  = p;
    tick();
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic pushExpect(input string tag, input longint unsigned bytes, input int reads);
    sb_q.push_back('{tag, bytes, reads, rd_total});
  endtask

  task automatic popScoreboard();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL sb_underflow observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      checkOutput({e.tag, "_bytes"}, byte_count, 64'(e.bytes));
      checkOutput({e.tag, "_reads"}, 64'(rd_total - e.base), 64'(e.reads));
    end
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    @(negedge clk_pcie);
    while (done !== 1'b1 && n < budget) begin
      tick();
      @(negedge clk_pcie);
      n++;
    end
    checkOutput({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    data_path_rst  = 1'b1;
    start          = 1'b0;
    stop           = 1'b0;
    capture_len    = 64'd0;
    src_empty      = 1'b1;
    src_full       = 1'b0;
    ddr3_fifo_full = 1'b0;
    tick();
    @(negedge clk_pcie);
    checkOutput("rst_state", 64'(state_o), 64'd0);
    checkOutput("rst_rec_en", 64'(rec_en), 64'd0);
    checkOutput("rst_rd_en", 64'(src_rd_en), 64'd0);
    checkOutput("rst_size_clear", 64'(size_clear), 64'd0);
    checkOutput("rst_bytes", byte_count, 64'd0);
    checkOutput("rst_busy_done_ovf", 64'({busy, done, overflow}), 64'd0);
`ifdef CAPTURE_TIMEOUT_EN
    checkOutput("rst_timeout", 64'(timeout), 64'd0);
`endif
    tick();
    data_path_rst = 1'b0;
    tick();

    // length 16: four reads, rec_en drops as DRAIN is entered, done 16 idle cycles later
    capture_len = 64'd16;
    src_empty   = 1'b0;
    pushExpect("t2", 64'd16, 4);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk_pcie);
    checkOutput("t2_size_clear_hi", 64'(size_clear), 64'd1);
    checkOutput("t2_state_clear", 64'(state_o), 64'd1);
    tick();
    @(negedge clk_pcie);
    checkOutput("t2_size_clear_lo", 64'(size_clear), 64'd0);
    checkOutput("t2_rec_en", 64'(rec_en), 64'd1);
    checkOutput("t2_read0", 64'(src_rd_en), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk_pcie);
      checkOutput("t2_read", 64'(src_rd_en), 64'd1);
    end
    tick();
    src_empty = 1'b1;
    @(negedge clk_pcie);
    checkOutput("t2_state_drain", 64'(state_o), 64'd3);
    checkOutput("t2_rec_en_off", 64'(rec_en), 64'd0);
    checkOutput("t2_bytes16", byte_count, 64'd16);
    repeat (15) tick();
    @(negedge clk_pcie);
    checkOutput("t2_not_done_yet", 64'(done), 64'd0);
    tick();
    @(negedge clk_pcie);
    checkOutput("t2_done", 64'(done), 64'd1);
    checkOutput("t2_state_done", 64'(state_o), 64'd4);
    popScoreboard();

    // length 10: three reads overshoot to 12, then nothing while data is still offered
    tick();
    capture_len = 64'd10;
    src_empty   = 1'b0;
    pushExpect("t3", 64'd12, 3);
    applyStimulus(1'b1, 1'b0);
    repeat (4) tick();
    viol = 0;
    repeat (4) begin
      @(negedge clk_pcie);
      if (src_rd_en !== 1'b0 || byte_count !== 64'd12 || state_o !== 3'd3) viol++;
      tick();
    end
    checkOutput("t3_no_extra_reads", 64'(viol), 64'd0);
    src_empty = 1'b1;
    waitDone("t3", 40);
    popScoreboard();

    // unlimited: 100 reads, stop, reads continue in DRAIN
    tick();
    capture_len = 64'd0;
    src_empty   = 1'b0;
    pushExpect("t4", 64'd412, 103);
    applyStimulus(1'b1, 1'b0);
    repeat (101) tick();
    src_empty = 1'b1;
    stop      = 1'b1;
    @(negedge clk_pcie);
    checkOutput("t4_bytes400", byte_count, 64'd400);
    checkOutput("t4_rec_en_before_stop", 64'(rec_en), 64'd1);
    tick();
    stop = 1'b0;
    @(negedge clk_pcie);
    checkOutput("t4_state_drain", 64'(state_o), 64'd3);
    checkOutput("t4_rec_en_off", 64'(rec_en), 64'd0);
    tick();
    src_empty = 1'b0;
    @(negedge clk_pcie);
    checkOutput("t4_drain_read", 64'(src_rd_en), 64'd1);
    repeat (3) tick();
    src_empty = 1'b1;
    waitDone("t4", 40);
    popScoreboard();

    // downstream backpressure stall, then overflow capture
    tick();
    capture_len = 64'd0;
    src_empty   = 1'b0;
    pushExpect("t5", 64'd16, 4);
    applyStimulus(1'b1, 1'b0);
    repeat (3) tick();
    ddr3_fifo_full = 1'b1;
    viol = 0;
    repeat (STALL) begin
      @(negedge clk_pcie);
      if (src_rd_en !== 1'b0 || byte_count !== 64'd8) viol++;
      tick();
    end
    ddr3_fifo_full = 1'b0;
    checkOutput("t5_stall_frozen", 64'(viol), 64'd0);
    @(negedge clk_pcie);
    checkOutput("t5_state_capture", 64'(state_o), 64'd2);
    checkOutput("t5_resume_read", 64'(src_rd_en), 64'd1);
    tick();
    src_full = 1'b1;
    @(negedge clk_pcie);
    checkOutput("t5_ovf_not_yet", 64'(overflow), 64'd0);
    tick();
    src_full  = 1'b0;
    src_empty = 1'b1;
    stop      = 1'b1;
    @(negedge clk_pcie);
    checkOutput("t5_ovf_set", 64'(overflow), 64'd1);
    tick();
    stop = 1'b0;
    waitDone("t5", 40);
    checkOutput("t5_ovf_held_done", 64'(overflow), 64'd1);
    popScoreboard();

    // next session clears overflow; reset mid-CAPTURE at byte_count 40
    tick();
    src_empty = 1'b0;
    applyStimulus(1'b1, 1'b0);
    tick();
    @(negedge clk_pcie);
    checkOutput("t5_ovf_cleared", 64'(overflow), 64'd0);
    checkOutput("t5_bytes_cleared", byte_count, 64'd0);
    repeat (10) tick();
    checkOutput("t1_bytes40", byte_count, 64'd40);
    data_path_rst = 1'b1;
    #1;
    checkOutput("t1_state", 64'(state_o), 64'd0);
    checkOutput("t1_rec_rd", 64'({rec_en, src_rd_en}), 64'd0);
    checkOutput("t1_bytes", byte_count, 64'd0);
    checkOutput("t1_ovf", 64'(overflow), 64'd0);
    tick();
    src_empty     = 1'b1;
    data_path_rst = 1'b0;
    tick();

    // start and stop together in IDLE: stop discarded
    capture_len = 64'd0;
    pushExpect("t6", 64'd0, 0);
    applyStimulus(1'b1, 1'b1);
    @(negedge clk_pcie);
    checkOutput("t6_state_clear", 64'(state_o), 64'd1);
    tick();
    @(negedge clk_pcie);
    checkOutput("t6_state_capture", 64'(state_o), 64'd2);
    checkOutput("t6_rec_en", 64'(rec_en), 64'd1);
`ifdef CAPTURE_TIMEOUT_EN
    repeat (7) tick();
    @(negedge clk_pcie);
    checkOutput("t6_wd_capture", 64'(state_o), 64'd2);
    checkOutput("t6_wd_timeout_lo", 64'(timeout), 64'd0);
    tick();
    @(negedge clk_pcie);
    checkOutput("t6_wd_drain", 64'(state_o), 64'd3);
    checkOutput("t6_wd_timeout_hi", 64'(timeout), 64'd1);
`else
    tick();
    applyStimulus(1'b0, 1'b1);
`endif
    waitDone("t6", 40);
    popScoreboard();
    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
